// File: rtl/seven_seg_scanner_if.sv
// Display scanner signal bundle: value/dots/control in, segment and digit pins out.
// master = display-value producer, slave = scanner.
interface seven_seg_scanner_if;
    logic [15:0] value;
    logic [3:0]  dots;
    logic        blank_zeros;
    logic        enable;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic        frame_done;

    modport master (
        output value, dots, blank_zeros, enable,
        input  abcdefgh, digit, frame_done
    );

    modport slave (
        input  value, dots, blank_zeros, enable,
        output abcdefgh, digit, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed 7-segment scanner with blanking guard, leading-zero blanking and per-frame latching.
// Latency: registered outputs, change on the same edge as the scan state; no backpressure, free-running scan.
module seven_seg_scanner #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    seven_seg_scanner_if.slave bus
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     value_sh_q, value_sh_d;
    logic [3:0]      dots_sh_q, dots_sh_d;
    logic            bz_sh_q, bz_sh_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      digit_q, digit_d;
    logic            frame_done_q, frame_done_d;

    // Segment patterns a..g, active-low.
    function automatic logic [6:0] decode7(input logic [3:0] n);
        case (n)
            4'h0: decode7 = 7'b0000001;
            4'h1: decode7 = 7'b1001111;
            4'h2: decode7 = 7'b0010010;
            4'h3: decode7 = 7'b0000110;
            4'h4: decode7 = 7'b1001100;
            4'h5: decode7 = 7'b0100100;
            4'h6: decode7 = 7'b0100000;
            4'h7: decode7 = 7'b0001111;
            4'h8: decode7 = 7'b0000000;
            4'h9: decode7 = 7'b0000100;
            4'hA: decode7 = 7'b0001000;
            4'hB: decode7 = 7'b1100000;
            4'hC: decode7 = 7'b0110001;
            4'hD: decode7 = 7'b1000010;
            4'hE: decode7 = 7'b0110000;
            default: decode7 = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            timer_q      <= '0;
            value_sh_q   <= '0;
            dots_sh_q    <= '0;
            bz_sh_q      <= 1'b0;
            seg_q        <= 8'hFF;
            digit_q      <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            value_sh_q   <= value_sh_d;
            dots_sh_q    <= dots_sh_d;
            bz_sh_q      <= bz_sh_d;
            seg_q        <= seg_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q + TW'(1);
        if (!bus.enable) begin
            state_d = ST_BLANK;
            idx_d   = 2'd0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (timer_q == TW'(BLANK_CYCLES - 1)) begin
                        state_d = ST_SHOW;
                        timer_d = '0;
                    end
                end
                default: begin
                    if (timer_q == TW'(DWELL_CYCLES - 1)) begin
                        state_d = ST_BLANK;
                        idx_d   = idx_q + 2'd1;
                        timer_d = '0;
                    end
                end
            endcase
        end
    end

    // Inputs are sampled only in the guard before digit 0 so a frame never mixes two values.
    always_comb begin
        value_sh_d = value_sh_q;
        dots_sh_d  = dots_sh_q;
        bz_sh_d    = bz_sh_q;
        if (state_q == ST_BLANK && idx_q == 2'd0) begin
            value_sh_d = bus.value;
            dots_sh_d  = bus.dots;
            bz_sh_d    = bus.blank_zeros;
        end
    end

    logic [3:0] nib;
    logic [6:0] seg7;
    logic       lead_zero;

    // Decode from the next-state shadow so digit 0 shows the value latched on its own entry edge.
    always_comb begin
        nib       = value_sh_d[{idx_d, 2'b00} +: 4];
        lead_zero = 1'b0;
        case (idx_d)
            2'd1:    lead_zero = (value_sh_d[15:4] == 12'h000);
            2'd2:    lead_zero = (value_sh_d[15:8] == 8'h00);
            2'd3:    lead_zero = (value_sh_d[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
        seg7 = decode7(nib);
        if (bz_sh_d && lead_zero) begin
            seg7 = 7'h7F;
        end
        seg_d        = 8'hFF;
        digit_d      = 4'hF;
        frame_done_d = 1'b0;
        if (state_d == ST_SHOW) begin
            seg_d        = {seg7, ~dots_sh_d[idx_d]};
            digit_d      = ~(4'b0001 << idx_d);
            frame_done_d = (idx_d == 2'd3) && (timer_d == TW'(DWELL_CYCLES - 1));
        end
    end

    assign bus.abcdefgh   = seg_q;
    assign bus.digit      = digit_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2; outputs sampled on the falling edge.
module tb_seven_seg_scanner;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] s, input logic [3:0] d, input logic f);
        checks++;
        assert (bus.abcdefgh === s) else begin
            errors++;
            $error("FAIL %s abcdefgh observed %h expected %h", tag, bus.abcdefgh, s);
        end
        checks++;
        assert (bus.digit === d) else begin
            errors++;
            $error("FAIL %s digit observed %b expected %b", tag, bus.digit, d);
        end
        checks++;
        assert (bus.frame_done === f) else begin
            errors++;
            $error("FAIL %s frame_done observed %b expected %b", tag, bus.frame_done, f);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] s, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, s, d, 1'b0);
            @(negedge clk);
        end
    endtask

    // Called on the first guard cycle of a digit; returns on the first guard cycle of the next.
    task automatic show_digit(input string tag, input logic [7:0] s, input logic [3:0] d, input logic last);
        run({tag, "_blank"}, 8'hFF, 4'hF, 2);
        run(tag, s, d, 3);
        chk({tag, "_end"}, s, d, last);
        @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        bus.value       = 16'h1234;
        bus.dots        = 4'h0;
        bus.blank_zeros = 1'b0;
        bus.enable      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset", 8'hFF, 4'hF, 1'b0);
        reset_n = 1'b1;

        // Basic scan of 1234, two frames; value changes mid digit 0 of frame 2.
        show_digit("f1_d0", 8'h99, 4'b1110, 1'b0);
        show_digit("f1_d1", 8'h0D, 4'b1101, 1'b0);
        show_digit("f1_d2", 8'h25, 4'b1011, 1'b0);
        show_digit("f1_d3", 8'h9F, 4'b0111, 1'b1);
        run("f2_blank", 8'hFF, 4'hF, 2);
        run("f2_d0a", 8'h99, 4'b1110, 2);
        bus.value = 16'hABCD;
        run("f2_d0b", 8'h99, 4'b1110, 1);
        chk("f2_d0_end", 8'h99, 4'b1110, 1'b0);
        @(negedge clk);
        show_digit("tear_d1", 8'h0D, 4'b1101, 1'b0);
        show_digit("tear_d2", 8'h25, 4'b1011, 1'b0);
        show_digit("tear_d3", 8'h9F, 4'b0111, 1'b1);
        show_digit("abcd_d0", 8'h85, 4'b1110, 1'b0);
        show_digit("abcd_d1", 8'h63, 4'b1101, 1'b0);
        show_digit("abcd_d2", 8'hC1, 4'b1011, 1'b0);
        show_digit("abcd_d3", 8'h11, 4'b0111, 1'b1);

        // Asynchronous reset in the middle of digit 0.
        run("pre_rst_blank", 8'hFF, 4'hF, 2);
        run("pre_rst_d0", 8'h85, 4'b1110, 2);
        reset_n = 1'b0;
        #1;
        chk("async_rst", 8'hFF, 4'hF, 1'b0);
        @(negedge clk);
        chk("rst_hold", 8'hFF, 4'hF, 1'b0);
        reset_n = 1'b1;
        show_digit("post_rst_d0", 8'h85, 4'b1110, 1'b0);
        show_digit("post_rst_d1", 8'h63, 4'b1101, 1'b0);
        show_digit("post_rst_d2", 8'hC1, 4'b1011, 1'b0);
        show_digit("post_rst_d3", 8'h11, 4'b0111, 1'b1);

        // Leading-zero blanking with a decimal point on a blanked digit.
        bus.blank_zeros = 1'b1;
        bus.value       = 16'h0050;
        bus.dots        = 4'b0100;
        show_digit("bz_d0", 8'h03, 4'b1110, 1'b0);
        show_digit("bz_d1", 8'h49, 4'b1101, 1'b0);
        show_digit("bz_d2", 8'hFE, 4'b1011, 1'b0);
        show_digit("bz_d3", 8'hFF, 4'b0111, 1'b1);

        // All segments and points lit.
        bus.value = 16'h8888;
        bus.dots  = 4'hF;
        show_digit("all_d0", 8'h00, 4'b1110, 1'b0);
        show_digit("all_d1", 8'h00, 4'b1101, 1'b0);
        show_digit("all_d2", 8'h00, 4'b1011, 1'b0);
        show_digit("all_d3", 8'h00, 4'b0111, 1'b1);

        // Enable drop during digit 2, then resume with a fresh frame.
        bus.blank_zeros = 1'b0;
        bus.value       = 16'h1234;
        bus.dots        = 4'h0;
        show_digit("en_d0", 8'h99, 4'b1110, 1'b0);
        show_digit("en_d1", 8'h0D, 4'b1101, 1'b0);
        run("en_d2_blank", 8'hFF, 4'hF, 2);
        run("en_d2", 8'h25, 4'b1011, 2);
        chk("en_drop_edge", 8'h25, 4'b1011, 1'b0);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_off", 8'hFF, 4'hF, 1'b0);
        end
        bus.enable = 1'b1;
        show_digit("resume_d0", 8'h99, 4'b1110, 1'b0);
        show_digit("resume_d1", 8'h0D, 4'b1101, 1'b0);
        show_digit("resume_d2", 8'h25, 4'b1011, 1'b0);
        show_digit("resume_d3", 8'h9F, 4'b0111, 1'b1);
        chk("next_frame", 8'hFF, 4'hF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed driver for the board's 4-digit common-select 7-segment display. It takes a 16-bit value plus per-digit decimal points and scans the digits, showing one hex digit at a time. It sits between any counter or status logic in a lab top and the board pins `abcdefgh` and `digit`. It is the display-side counterpart to the key-driven counters, replacing the constant "display off" tie-offs.

Parameters:
- DWELL_CYCLES, 50000, clock cycles each digit is lit (1 ms at 50 MHz). Must be >= 1.
- BLANK_CYCLES, 16, clock cycles with all digits off between digit switches, as an anti-ghosting guard. Must be >= 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low. The single clock is `clk`.
- value  input  16  number to display; nibble k goes to digit k, and digit 0 is rightmost, `value[3:0]`.
- dots  input  4  `dots[k]=1` lights the decimal point of digit k.
- blank_zeros  input  1  1 = suppress leading zeros.
- enable  input  1  0 = display off, scan held at its start.
- abcdefgh  output  8  segments, active-low. Bit 7 = a … bit 1 = g, bit 0 = h (dp).
- digit  output  4  digit selects, active-low. `digit[k]` selects digit k.
- frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- Reset (`reset_n`=0, asynchronous):
  - State = BLANK, idx = 0, timer = 0.
  - Shadow registers = 0.
  - `abcdefgh` = 8'hFF, `digit` = 4'hF, `frame_done` = 0.
- All outputs are registered and update on the same edge as the state. Output timing below is stated as cycles observed at the pins.
- BLANK state:
  - Outputs are `digit` = 4'hF, `abcdefgh` = 8'hFF, for exactly BLANK_CYCLES cycles.
  - Then go to SHOW with the same idx.
- SHOW state:
  - Outputs are `digit` = ~(4'b1 << idx) and `abcdefgh` = decode(shadow nibble idx), for exactly DWELL_CYCLES cycles.
  - Then go to BLANK with idx = (idx+1) mod 4.
  - On the last SHOW cycle with idx = 3, assert `frame_done` for 1 cycle; idx then wraps to 0.
- Frame period is 4*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Anti-tearing:
  - The shadow copies of `value`, `dots` and `blank_zeros` load on every clock edge while state = BLANK and idx = 0.
  - The shadows are frozen for the rest of the frame, so input changes mid-frame appear only in the next frame.
- Decode, listed as lit segments (lit = 0):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg
  - 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg
  - C adef, d bcdeg, E adefg, F aefg
  - h is lit (0) if the shadow dots bit for idx is 1.
- Leading-zero blanking:
  - Applies when shadow blank_zeros = 1, for idx >= 1 where shadow nibbles idx..3 are all zero.
  - Segments a–g are forced off; the dp still follows dots and the digit select is still asserted.
  - Digit 0 is never blanked.
- enable = 0:
  - On the next edge, state = BLANK, idx = 0, timer = 0, and outputs are off.
  - The block holds there, no `frame_done` is issued, and the shadow keeps tracking the inputs.
  - When enable rises, a fresh frame starts with a full BLANK_CYCLES period.
- Timer width is `$clog2` of max(DWELL_CYCLES, BLANK_CYCLES)+1. There is no wrap within a state; the timer resets on every state change.

Test Plan:
All scenarios use DWELL_CYCLES = 4, BLANK_CYCLES = 2, enable = 1 unless stated.
1. Reset:
   - Stimulus: drop `reset_n` mid-SHOW.
   - Response: `abcdefgh` = FF, `digit` = F with no clock edge needed. After release, 2 cycles of F/FF, then `digit` = 4'b1110 for 4 cycles.
2. Basic scan:
   - Stimulus: `value` = 16'h1234, `dots` = 0.
   - Response: 8'h99 with `digit` = 1110, then 8'h0D with 1101, then 8'h25 with 1011, then 8'h9F with 0111. Each is held 4 cycles with 2 F/FF cycles between. `frame_done` pulses on cycle 24, then the frame repeats.
3. Anti-tearing:
   - Stimulus: switch `value` to 16'hABCD while digit 0 is lit.
   - Response: the rest of the frame still shows 0D/25/9F. The next frame shows 8'h85 (d), then 8'h63 (C), 8'hC1 (b), 8'h11 (A).
4. Zero blanking and dp:
   - Stimulus: `blank_zeros` = 1, `value` = 16'h0050, `dots` = 4'b0100.
   - Response: digit0 = 8'h03, digit1 = 8'h49, digit2 = 8'hFE, digit3 = 8'hFF.
5. Enable drop and resume:
   - Stimulus: drop `enable` during digit 2 SHOW, hold 5 cycles, then re-assert.
   - Response: outputs are off from the next edge and there is no `frame_done`. After re-assert, 2 off cycles, then digit 0.
6. All segments lit:
   - Stimulus: `value` = 16'h8888, `dots` = 4'hF.
   - Response: every digit shows `abcdefgh` = 8'h00.
